// File: rtl/reorder_buffer_pkg.sv
// Common types shared across the out-of-order core: tag and register widths
// and the common data bus broadcast.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int REG_WIDTH = 5;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results,
// forwards operands and retires results strictly in program order.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 2**ROB_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  logic [REG_WIDTH-1:0] issue_arch_num,
    output logic                 issue_ready,
    output logic [ROB_WIDTH-1:0] issue_tag,
    input  cdb_t                 cdb,
    input  logic [ROB_WIDTH-1:0] read_tag [2],
    output cdb_t                 rob_read [2],
    output logic                 commit,
    output logic [REG_WIDTH-1:0] commit_arch_num,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data,
    output logic                 empty
);

    localparam logic [ROB_WIDTH-1:0] LAST = ROB_WIDTH'(DEPTH - 1);
    localparam logic [ROB_WIDTH:0]   FULL = (ROB_WIDTH+1)'(DEPTH);

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic [DEPTH-1:0]     done;
    logic [REG_WIDTH-1:0] arch [DEPTH];
    logic [31:0]          data [DEPTH];
    logic                 issue_fire;

    // Credit comes only from registered count; a same-cycle commit frees nothing.
    assign issue_ready     = count < FULL;
    assign issue_fire      = issue && issue_ready;
    assign issue_tag       = tail;
    assign empty           = count == '0;
    assign commit          = !empty && done[head];
    assign commit_tag      = head;
    assign commit_arch_num = arch[head];
    assign commit_data     = data[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            if (commit) begin
                done[head] <= 1'b0;
                head       <= (head == LAST) ? '0 : head + 1'b1;
            end
            if (issue_fire) begin
                done[tail] <= 1'b0;
                tail       <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            // A CDB only ever targets an occupied entry, so it never collides with the clears above.
            if (cdb.valid)
                done[cdb.tag] <= 1'b1;
            case ({issue_fire, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is qualified by the done bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (issue_fire)
            arch[tail] <= issue_arch_num;
        if (cdb.valid)
            data[cdb.tag] <= cdb.data;
    end

    // Operand lookup with same-cycle CDB bypass.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rob_read[i]     = '0;
            rob_read[i].tag = read_tag[i];
            if (cdb.valid && cdb.tag == read_tag[i]) begin
                rob_read[i].valid = 1'b1;
                rob_read[i].data  = cdb.data;
            end else begin
                rob_read[i].valid = done[read_tag[i]];
                rob_read[i].data  = data[read_tag[i]];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios plus random traffic
// checked against an in-order queue model of the buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 issue;
    logic [REG_WIDTH-1:0] issue_arch_num;
    logic                 issue_ready;
    logic [ROB_WIDTH-1:0] issue_tag;
    cdb_t                 cdb;
    logic [ROB_WIDTH-1:0] read_tag [2];
    cdb_t                 rob_read [2];
    logic                 commit;
    logic [REG_WIDTH-1:0] commit_arch_num;
    logic [ROB_WIDTH-1:0] commit_tag;
    logic [31:0]          commit_data;
    logic                 empty;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue(issue), .issue_arch_num(issue_arch_num),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb(cdb), .read_tag(read_tag), .rob_read(rob_read),
        .commit(commit), .commit_arch_num(commit_arch_num),
        .commit_tag(commit_tag), .commit_data(commit_data),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          arch;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];      // occupied entries in program order
    int          pend[$];       // occupied entries still awaiting a result
    bit          done_m [DEPTH];
    logic [31:0] data_m [DEPTH];
    logic [31:0] plan_m [DEPTH];
    int          commit_cyc [DEPTH];
    int          occ, tail_m, cyc;
    bit          acc_prev, com_prev, cdb_prev, mon_en;
    int          acc_prev_tag, cdb_prev_tag;
    int          checks, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every visible output against the model each cycle.
    always @(negedge clk) begin
        bit exp_c;
        if (mon_en) begin
            cyc++;
            chk("issue_ready", 32'(issue_ready), 32'(occ < DEPTH));
            chk("empty", 32'(empty), 32'(occ == 0));
            chk("issue_tag", 32'(issue_tag), 32'(tail_m));
            for (int i = 0; i < 2; i++) begin
                int rt;
                bit byp, ev;
                rt  = int'(read_tag[i]);
                byp = cdb.valid && int'(cdb.tag) == rt;
                ev  = byp || done_m[rt];
                chk("rob_read_valid", 32'(rob_read[i].valid), 32'(ev));
                if (ev)
                    chk("rob_read_data", rob_read[i].data, byp ? cdb.data : data_m[rt]);
            end
            exp_c = exp_q.size() > 0 && done_m[exp_q[0].tag];
            chk("commit", 32'(commit), 32'(exp_c));
            com_prev = commit && exp_c;
            if (com_prev) begin
                chk("commit_tag", 32'(commit_tag), 32'(exp_q[0].tag));
                chk("commit_arch", 32'(commit_arch_num), 32'(exp_q[0].arch));
                chk("commit_data", commit_data, exp_q[0].data);
                done_m[exp_q[0].tag]     = 1'b0;
                commit_cyc[exp_q[0].tag] = cyc;
                void'(exp_q.pop_front());
            end
        end
    end

    // Fold the effects of the edge just passed into the model.
    task automatic update();
        if (acc_prev) begin
            pend.push_back(acc_prev_tag);
            tail_m = (tail_m + 1) % DEPTH;
        end
        if (cdb_prev) begin
            done_m[cdb_prev_tag] = 1'b1;
            data_m[cdb_prev_tag] = plan_m[cdb_prev_tag];
        end
        occ      = occ + int'(acc_prev) - int'(com_prev);
        com_prev = 1'b0;
    endtask

    // ctag: -1 no CDB, -2 random pending entry, else that tag. rt0: -1 random read tag.
    task automatic drive(input bit want, input int arch, input logic [31:0] d,
                         input int ctag, input int rt0);
        int idx;
        issue          = want;
        issue_arch_num = REG_WIDTH'(arch);
        acc_prev       = want && occ < DEPTH;
        if (acc_prev) begin
            acc_prev_tag   = tail_m;
            plan_m[tail_m] = d;
            exp_q.push_back('{tag: tail_m, arch: arch, data: d});
        end
        idx = -1;
        if (ctag == -2 && pend.size() > 0)
            idx = int'($urandom_range(0, pend.size() - 1));
        else if (ctag >= 0)
            foreach (pend[k]) if (pend[k] == ctag) idx = k;
        cdb_prev = idx >= 0;
        if (cdb_prev) begin
            cdb_prev_tag = pend[idx];
            pend.delete(idx);
            cdb.valid = 1'b1;
            cdb.tag   = ROB_WIDTH'(cdb_prev_tag);
            cdb.data  = plan_m[cdb_prev_tag];
        end else begin
            cdb = '0;
        end
        read_tag[0] = (rt0 >= 0) ? ROB_WIDTH'(rt0) : ROB_WIDTH'($urandom_range(0, DEPTH - 1));
        read_tag[1] = ROB_WIDTH'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic cycle(input bit want, input int arch, input logic [31:0] d,
                         input int ctag, input int rt0);
        @(posedge clk);
        #1;
        update();
        drive(want, arch, d, ctag, rt0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        issue  = 1'b0;
        issue_arch_num = '0;
        cdb    = '0;
        read_tag[0] = '0;
        read_tag[1] = '0;
        exp_q.delete();
        pend.delete();
        foreach (done_m[i]) done_m[i] = 1'b0;
        occ = 0; tail_m = 0;
        acc_prev = 1'b0; com_prev = 1'b0; cdb_prev = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() > 0; n++)
            cycle(1'b0, 0, 32'h0, -2, -1);
        chk("drain_empty_model", 32'(exp_q.size()), 32'd0);
        repeat (2) cycle(1'b0, 0, 32'h0, -1, -1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        mon_en = 1'b0;
        reset  = 1'b1;

        // Single issue, result, commit, back to empty.
        do_reset();
        cycle(1'b1, 5, 32'h3F800000, -1, -1);
        cycle(1'b0, 0, 32'h0, 0, -1);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        chk("t1_commit", 32'(commit), 32'd1);
        chk("t1_arch", 32'(commit_arch_num), 32'd5);
        chk("t1_data", commit_data, 32'h3F800000);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        chk("t1_empty", 32'(empty), 32'd1);

        // Out-of-order results retire in order on consecutive cycles.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 10 + i, $urandom, -1, -1);
        cycle(1'b0, 0, 32'h0, 2, -1);
        cycle(1'b0, 0, 32'h0, 1, -1);
        cycle(1'b0, 0, 32'h0, 0, -1);
        repeat (4) cycle(1'b0, 0, 32'h0, -1, -1);
        chk("t2_gap01", 32'(commit_cyc[1] - commit_cyc[0]), 32'd1);
        chk("t2_gap12", 32'(commit_cyc[2] - commit_cyc[1]), 32'd1);

        // Full buffer rejects issue; freed slot becomes available with wrapped tag.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, i, $urandom, -1, -1);
        cycle(1'b1, 31, 32'hDEADBEEF, -1, -1);
        #1;
        chk("t3_full", 32'(issue_ready), 32'd0);
        cycle(1'b0, 0, 32'h0, 0, -1);
        cycle(1'b0, 0, 32'h0, -1, -1);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        chk("t3_ready_again", 32'(issue_ready), 32'd1);
        chk("t3_wrap_tag", 32'(issue_tag), 32'd0);
        cycle(1'b1, 7, $urandom, -1, -1);
        drain();

        // Operand lookup bypasses the CDB in the broadcast cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, i, $urandom, -1, -1);
        cycle(1'b1, 3, 32'h12345678, -1, -1);
        cycle(1'b0, 0, 32'h0, 3, 3);
        #1;
        chk("t4_byp_valid", 32'(rob_read[0].valid), 32'd1);
        chk("t4_byp_data", rob_read[0].data, 32'h12345678);
        drain();

        // Reset mid-cycle with pending entries, then issue on the first edge after.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, i, $urandom, -1, -1);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("t5_commit", 32'(commit), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_issue_tag", 32'(issue_tag), 32'd0);
        chk("t5_issue_ready", 32'(issue_ready), 32'd1);
        do_reset();
        drive(1'b1, 9, 32'hCAFEF00D, -1, -1);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        chk("t5_first_issue", 32'(issue_tag), 32'd1);
        drain();

        // Simultaneous issue and commit at occupancy three.
        do_reset();
        cycle(1'b1, 1, $urandom, -1, -1);
        cycle(1'b1, 2, $urandom, -1, -1);
        cycle(1'b1, 3, $urandom, 0, -1);
        cycle(1'b1, 4, $urandom, -1, -1);
        #1;
        chk("t6_commit", 32'(commit), 32'd1);
        chk("t6_commit_tag", 32'(commit_tag), 32'd0);
        cycle(1'b0, 0, 32'h0, -1, -1);
        #1;
        chk("t6_tail", 32'(issue_tag), 32'd4);
        chk("t6_occ", 32'(occ), 32'd3);
        drain();

        // Random traffic.
        do_reset();
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) != 0) ? -2 : -1, -1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
